mem_ws: RTL

Parametrised single-port data memory with per-byte write enables, registered read data and a programmable wait-state engine behind a valid/ready request handshake. It is the next-generation data memory for the hardware-scheduled pipeline: the MEM stage issues one request at a time and stalls on `o_ready`/`o_rvalid`, so the pipeline's hazard and stall logic can be exercised against slow memory.

---
 rtl/mem_ws_pkg.sv | 17 +
 rtl/mem_ws_byte_ram.sv | 27 ++
 rtl/mem_ws.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_ws_pkg.sv
// Shared types and constants for the wait-state data memory.
// Holds the FSM state encoding, the wait counter width and the byte-lane helper.
package mem_ws_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   function automatic int lanes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mem_ws_byte_ram.sv
// Byte-lane word array: synchronous per-lane writes, combinational word read.
// The stored contents are not cleared by reset.
module mem_byte_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH/8-1:0]   we,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     rdata
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   // NOTE: the array sits outside the reset domain; resetting storage would block RAM inference.
   always_ff @(posedge clk) begin
      for (int l = 0; l < DATA_WIDTH/8; l++) begin
         if (we[l]) begin
            mem_q[addr][l*8 +: 8] <= wdata[l*8 +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_ws.sv
// Single-port data memory with byte enables, registered response and a
// programmable wait-state engine behind a valid/ready request handshake.
module mem_ws
   import mem_ws_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic                      i_CLK,
   input  logic                      i_RST_N,
   input  logic                      i_req,
   input  logic                      i_we,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic [DATA_WIDTH/8-1:0]   i_be,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   output logic                      o_ready,
   output logic                      o_rvalid,
   output logic                      o_resp_we,
   output logic [DATA_WIDTH-1:0]     o_rdata
);

   localparam int LANES = lanes(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  resp_we_q, resp_we_d;
   logic [DATA_WIDTH-1:0] ram_rdata, merged;
   logic [LANES-1:0]      lane_we;
   logic                  accept;

   assign o_ready   = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign o_rvalid  = (state_q == ST_RESP);
   assign o_rdata   = rdata_q;
   assign o_resp_we = resp_we_q;
   assign accept    = i_req && o_ready;

   // Reset held at the edge suppresses the array write as well as the FSM.
   assign lane_we = (accept && i_we && i_RST_N) ? i_be : '0;

   // Post-write word: enabled lanes take the new data, the rest the stored word.
   always_comb begin
      merged = ram_rdata;
      for (int l = 0; l < LANES; l++) begin
         if (lane_we[l]) begin
            merged[l*8 +: 8] = i_wdata[l*8 +: 8];
         end
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      resp_we_d = resp_we_q;

      if (accept) begin
         rdata_d   = merged;
         resp_we_d = i_we;
      end

      unique case (state_q)
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rdata_q   <= '0;
         resp_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         resp_we_q <= resp_we_d;
      end
   end

   mem_byte_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (i_CLK),
      .addr  (i_addr),
      .we    (lane_we),
      .wdata (i_wdata),
      .rdata (ram_rdata)
   );

endmodule
